// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel window sequencer.
package sobel_pkg;

  localparam int DEF_W  = 1280;
  localparam int DEF_H  = 720;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Counter width for an index range 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of window element (y,x); y=0 is the top row, x=0 the left column.
  function automatic int win_off(input int y, input int x, input int dw);
    return dw * (3 * y + x);
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two single-row pixel memories sharing one column address; row_a holds row r-1, row_b row r-2.
module sobel_line_buf #(
  parameter int W  = 1280,
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] row_a,
  output logic [DW-1:0] row_b
);

  logic [DW-1:0] mem_a [W];
  logic [DW-1:0] mem_b [W];

  assign row_a = mem_a[addr];
  assign row_b = mem_b[addr];

  // On each write the column ages by one row: A moves down to B, the new pixel lands in A.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_b[addr] <= mem_a[addr];
      mem_a[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel window sequencer: accepts a raster pixel stream and emits one 3x3 neighbourhood
// per interior pixel, with its centre coordinates, under valid/ready flow control.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int H  = DEF_H,
  parameter int DW = DEF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DW-1:0]       Din,
  input  logic                data_valid,
  output logic                fill_now,
  output logic [9*DW-1:0]     win,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [idx_w(H)-1:0] win_row,
  output logic [idx_w(W)-1:0] win_col,
  output logic                busy,
  output logic                done
);

  localparam int RW = idx_w(H);
  localparam int CW = idx_w(W);

  state_t        state;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [DW-1:0] above1;
  logic [DW-1:0] above2;
  logic          accept;
  logic          emit;
  logic          last_col;
  logic          last_pix;

  sobel_line_buf #(.W(W), .DW(DW), .AW(CW)) u_line_buf (
    .clk  (clk),
    .we   (accept),
    .addr (c),
    .din  (Din),
    .row_a(above1),
    .row_b(above2)
  );

  // Input is held off whenever a presented window has not been taken.
  assign fill_now = (state == STREAM) && (!win_valid || win_ready);
  assign accept   = data_valid && fill_now;
  assign last_col = (c == CW'(W - 1));
  assign last_pix = last_col && (r == RW'(H - 1));
  // Columns 0/1 of a row still hold the previous row's tail, so they never complete a window.
  assign emit     = (r >= RW'(2)) && (c >= CW'(2));

  // Frame FSM, raster counters, window shift register and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end
      if (accept) begin
        for (int y = 0; y < 3; y++) begin
          win[win_off(y, 0, DW) +: DW] <= win[win_off(y, 1, DW) +: DW];
          win[win_off(y, 1, DW) +: DW] <= win[win_off(y, 2, DW) +: DW];
        end
        win[win_off(0, 2, DW) +: DW] <= above2;
        win[win_off(1, 2, DW) +: DW] <= above1;
        win[win_off(2, 2, DW) +: DW] <= Din;
        if (emit) begin
          win_valid <= 1'b1;
          win_row   <= r - RW'(1);
          win_col   <= c - CW'(1);
        end
        if (last_col) begin
          c <= '0;
          r <= r + RW'(1);
        end else begin
          c <= c + CW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            r     <= '0;
            c     <= '0;
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (accept && last_pix) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!win_valid || win_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on an 8x6 image: expected windows come from the image array.
module tb_sobel_window_ctrl;

  localparam int W = 8, H = 6, DW = 8;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);
  localparam int S_IDLE = 0, S_STREAM = 1, S_FLUSH = 2;

  typedef struct {
    logic [9*DW-1:0] w;
    int              row;
    int              col;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            data_valid = 1'b0;
  logic            win_ready = 1'b0;
  logic [DW-1:0]   din = '0;
  logic            fill_now, win_valid, busy, done;
  logic [9*DW-1:0] win;
  logic [2:0]      win_row, win_col;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] img [NPIX];
  exp_t          sb [$];
  int            ms = S_IDLE;
  int            k = 0;
  int            n_emit = 0;
  int            n_pop = 0;
  bit            mv = 1'b0;
  bit            mdone = 1'b0;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.W(W), .H(H), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Din       (din),
    .data_valid(data_valid),
    .fill_now  (fill_now),
    .win       (win),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops the oldest expected window.
  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (win_valid === 1'b1 && win_ready === 1'b1 && rst === 1'b0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got window row %0d col %0d expected none", win_row, win_col);
      end else begin
        e = sb.pop_front();
        chk("win", 72'(win), 72'(e.w));
        chk("win_row", 72'(win_row), 72'(e.row));
        chk("win_col", 72'(win_col), 72'(e.col));
        n_pop++;
      end
    end
  end

  // One clock of stimulus: drive at negedge, check control outputs, then advance the model.
  task automatic cycle(input bit dv, input bit rdy, input bit st, input bit rs);
    bit   m_fill, acc, nmv;
    int   rr, cc;
    exp_t e;
    @(negedge clk);
    rst        = rs;
    data_valid = dv;
    win_ready  = rdy;
    start      = st;
    din        = (k < NPIX) ? img[k] : '0;
    #1;
    if (rs) begin
      ms = S_IDLE;
      mv = 1'b0;
      mdone = 1'b0;
      sb.delete();
      return;
    end
    m_fill = (ms == S_STREAM) && (!mv || rdy);
    chk("fill_now", 72'(fill_now), 72'(m_fill));
    chk("win_valid", 72'(win_valid), 72'(mv));
    chk("busy", 72'(busy), 72'(ms != S_IDLE));
    chk("done", 72'(done), 72'(mdone));
    acc   = dv && m_fill;
    mdone = 1'b0;
    nmv   = mv && !rdy;
    case (ms)
      S_IDLE: begin
        if (st) begin
          ms = S_STREAM;
          k = 0;
          n_emit = 0;
        end
      end
      S_STREAM: begin
        if (acc) begin
          rr = k / W;
          cc = k % W;
          nmv = 1'b0;
          if (rr >= 2 && cc >= 2) begin
            for (int y = 0; y < 3; y++)
              for (int x = 0; x < 3; x++)
                e.w[DW*(3*y+x) +: DW] = img[(rr - 2 + y) * W + (cc - 2 + x)];
            e.row = rr - 1;
            e.col = cc - 1;
            sb.push_back(e);
            nmv = 1'b1;
            n_emit++;
          end
          k++;
          if (k == NPIX) ms = S_FLUSH;
        end
      end
      default: begin
        if (!mv || rdy) begin
          ms = S_IDLE;
          mdone = 1'b1;
        end
      end
    endcase
    mv = nmv;
  endtask

  // dvm: 0 always valid, 1 toggling, 2 random; rdm: 0 always ready, 1 stall at window 3, 2 random.
  task automatic run_frame(input int dvm, input int rdm, input bit spam, input int abort_at);
    int cyc = 0;
    int stall = 5;
    int pop0;
    bit dv, rdy, st;
    pop0 = n_pop;
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    while (ms != S_IDLE && cyc < 2000) begin
      if (abort_at >= 0 && k == abort_at) begin
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort_win", 72'(win), 72'(0));
        chk("abort_row", 72'(win_row), 72'(0));
        chk("abort_col", 72'(win_col), 72'(0));
        return;
      end
      dv  = (dvm == 0) ? 1'b1 : (dvm == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      rdy = 1'b1;
      if (rdm == 1 && n_emit == 3 && mv && stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else if (rdm == 2) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      st = spam && ($urandom_range(0, 5) == 0);
      cycle(dv, rdy, st, 1'b0);
      cyc++;
    end
    if (cyc >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: got no end of frame after %0d cycles expected done", cyc);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("win_count", 72'(n_pop - pop0), 72'(NWIN));
    chk("sb_empty", 72'(sb.size()), 72'(0));
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) img[i] = 8'((i / W) * 8 + (i % W));
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_win", 72'(win), 72'(0));
    chk("rst_row", 72'(win_row), 72'(0));
    chk("rst_col", 72'(win_col), 72'(0));

    run_frame(0, 0, 1'b0, -1);
    run_frame(0, 1, 1'b0, -1);
    run_frame(0, 0, 1'b1, -1);
    run_frame(0, 0, 1'b0, 30);
    run_frame(0, 0, 1'b0, -1);
    run_frame(1, 0, 1'b0, -1);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
      run_frame(2, 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
